// File: rtl/pipe_hazard_sched_if.sv
// -----------------------------------------------------------------------------
// pipe_hazard_sched_if
// Bundles the hazard-event inputs and the stall/flush control outputs of the
// pipeline hazard scheduler. The scheduler itself connects through the slave
// modport. The pipeline side (event producer / control consumer) uses master.
//
// Signals:
//   ld_use_hazard, mc_start, mc_cycles[CNT_W-1:0], mem_req, mem_ready,
//   branch_taken                         : pipeline -> scheduler
//   stall_stage[4:0], flush_stage[4:0],
//   pc_redirect, mc_busy, state_o[1:0]   : scheduler -> pipeline
//   perf_stall_cyc[31:0], perf_flush_evt[31:0]
//                                        : only when PIPE_PERF_CNT_EN is defined
// -----------------------------------------------------------------------------
interface pipe_hazard_sched_if #(
   parameter int CNT_W = 6
);
   logic             ld_use_hazard;
   logic             mc_start;
   logic [CNT_W-1:0] mc_cycles;
   logic             mem_req;
   logic             mem_ready;
   logic             branch_taken;
   logic [4:0]       stall_stage;
   logic [4:0]       flush_stage;
   logic             pc_redirect;
   logic             mc_busy;
   logic [1:0]       state_o;
`ifdef PIPE_PERF_CNT_EN
   logic [31:0]      perf_stall_cyc;
   logic [31:0]      perf_flush_evt;
`endif

`ifdef PIPE_PERF_CNT_EN
   modport slave (
      input  ld_use_hazard, mc_start, mc_cycles, mem_req, mem_ready, branch_taken,
      output stall_stage, flush_stage, pc_redirect, mc_busy, state_o,
      output perf_stall_cyc, perf_flush_evt
   );
   modport master (
      output ld_use_hazard, mc_start, mc_cycles, mem_req, mem_ready, branch_taken,
      input  stall_stage, flush_stage, pc_redirect, mc_busy, state_o,
      input  perf_stall_cyc, perf_flush_evt
   );
`else
   modport slave (
      input  ld_use_hazard, mc_start, mc_cycles, mem_req, mem_ready, branch_taken,
      output stall_stage, flush_stage, pc_redirect, mc_busy, state_o
   );
   modport master (
      output ld_use_hazard, mc_start, mc_cycles, mem_req, mem_ready, branch_taken,
      input  stall_stage, flush_stage, pc_redirect, mc_busy, state_o
   );
`endif
endinterface

// File: rtl/pipe_hazard_sched.sv
// -----------------------------------------------------------------------------
// pipe_hazard_sched
// Central stall/flush scheduler for the 5-stage pipeline (IF, ID, EX, MEM, WB).
// Arbitrates data-memory wait, taken branch, multi-cycle EX op and load-use
// hazard. It produces per-stage hold and bubble-insert vectors and a PC
// redirect strobe. Vector bit order: bit0=IF, bit1=ID, bit2=EX, bit3=MEM,
// bit4=WB.
//
// Ports:
//   clk    : pipeline clock, rising edge
//   reset  : asynchronous active-low reset; while low all outputs read 0
//   sched  : pipe_hazard_sched_if.slave (hazard inputs, control outputs)
//
// Optional feature macro: PIPE_PERF_CNT_EN
//   When defined, this adds the perf_stall_cyc and perf_flush_evt counters.
//   perf_stall_cyc counts the cycles in which any stage is held. It is
//   exposed through the interface.
//   perf_flush_evt counts the cycles in which pc_redirect is asserted. It is
//   exposed through the interface.
// -----------------------------------------------------------------------------
module pipe_hazard_sched #(
   parameter int CNT_W = 6
) (
   input  logic                clk,
   input  logic                reset,
   pipe_hazard_sched_if.slave  sched
);

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      MC_STALL  = 2'd1,
      MEM_STALL = 2'd2
   } state_t;

   localparam logic [4:0] STALL_MEM = 5'b01111;
   localparam logic [4:0] FLUSH_MEM = 5'b10000;
   localparam logic [4:0] STALL_MC  = 5'b00111;
   localparam logic [4:0] FLUSH_MC  = 5'b01000;
   localparam logic [4:0] STALL_LU  = 5'b00011;
   localparam logic [4:0] FLUSH_LU  = 5'b00100;
   localparam logic [4:0] FLUSH_BR  = 5'b00011;

   state_t           state_r;
   state_t           next_state_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_next_s;
   logic [4:0]       stall_s;
   logic [4:0]       flush_s;
   logic             redirect_s;
   logic             busy_s;

   // State and multi-cycle counter registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= RUN;
         cnt_r   <= '0;
      end else begin
         state_r <= next_state_s;
         cnt_r   <= cnt_next_s;
      end
   end

   // Next-state, counter update and raw control outputs
   always_comb begin
      next_state_s = state_r;
      cnt_next_s   = cnt_r;
      stall_s      = 5'b00000;
      flush_s      = 5'b00000;
      redirect_s   = 1'b0;
      busy_s       = 1'b0;
      case (state_r)
         RUN: begin
            cnt_next_s = '0;
            if (sched.mem_req && !sched.mem_ready) begin
               stall_s      = STALL_MEM;
               flush_s      = FLUSH_MEM;
               next_state_s = MEM_STALL;
            end else if (sched.branch_taken) begin
               // The redirect squashes IF/ID, so the younger hazards are moot.
               flush_s      = FLUSH_BR;
               redirect_s   = 1'b1;
               next_state_s = RUN;
            end else if (sched.mc_start && (sched.mc_cycles >= CNT_W'(2))) begin
               // The issue cycle is the first of mc_cycles-1 stall cycles.
               // The remaining count is therefore mc_cycles-2.
               stall_s    = STALL_MC;
               flush_s    = FLUSH_MC;
               cnt_next_s = sched.mc_cycles - CNT_W'(2);
               if (sched.mc_cycles == CNT_W'(2)) begin
                  next_state_s = RUN;
               end else begin
                  next_state_s = MC_STALL;
               end
            end else if (sched.ld_use_hazard) begin
               stall_s      = STALL_LU;
               flush_s      = FLUSH_LU;
               next_state_s = RUN;
            end else begin
               next_state_s = RUN;
            end
         end
         MC_STALL: begin
            stall_s = STALL_MC;
            flush_s = FLUSH_MC;
            busy_s  = 1'b1;
            // cnt <= 1 also covers a zero count, so the counter cannot wrap.
            if (cnt_r <= CNT_W'(1)) begin
               cnt_next_s   = '0;
               next_state_s = RUN;
            end else begin
               cnt_next_s   = cnt_r - CNT_W'(1);
               next_state_s = MC_STALL;
            end
         end
         MEM_STALL: begin
            if (!sched.mem_ready) begin
               stall_s      = STALL_MEM;
               flush_s      = FLUSH_MEM;
               next_state_s = MEM_STALL;
            end else begin
               next_state_s = RUN;
            end
         end
         default: begin
            cnt_next_s   = '0;
            next_state_s = RUN;
         end
      endcase
   end

   // Outputs are gated with reset so that they clear asynchronously even when
   // hazard inputs remain asserted.
   assign sched.stall_stage = reset ? stall_s : 5'b00000;
   assign sched.flush_stage = reset ? flush_s : 5'b00000;
   assign sched.pc_redirect = reset ? redirect_s : 1'b0;
   assign sched.mc_busy     = reset ? busy_s : 1'b0;
   assign sched.state_o     = state_r;

`ifdef PIPE_PERF_CNT_EN
   logic [31:0] perf_stall_r;
   logic [31:0] perf_flush_r;

   // Performance counters (wrap modulo 2^32)
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_stall_r <= 32'd0;
         perf_flush_r <= 32'd0;
      end else begin
         if (sched.stall_stage != 5'b00000) begin
            perf_stall_r <= perf_stall_r + 32'd1;
         end else begin
            perf_stall_r <= perf_stall_r;
         end
         if (sched.pc_redirect) begin
            perf_flush_r <= perf_flush_r + 32'd1;
         end else begin
            perf_flush_r <= perf_flush_r;
         end
      end
   end

   assign sched.perf_stall_cyc = perf_stall_r;
   assign sched.perf_flush_evt = perf_flush_r;
`endif

endmodule

// File: tb/tb_pipe_hazard_sched.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_sched
// Directed scoreboard bench for pipe_hazard_sched. Each step drives one cycle
// of inputs just after a rising edge and queues the expected outputs for that
// cycle. A falling-edge process pops each entry and compares it with the
// outputs.
// Packed expectation: {stall[4:0], flush[4:0], pc_redirect, mc_busy, state[1:0]}.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_sched;
   localparam int CNT_W = 6;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   pipe_hazard_sched_if #(.CNT_W(CNT_W)) sched ();

   pipe_hazard_sched #(.CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .sched (sched)
   );

   typedef struct {
      string       tag;
      logic [13:0] val;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   function automatic logic [13:0] observed();
      return {sched.stall_stage, sched.flush_stage, sched.pc_redirect,
              sched.mc_busy, sched.state_o};
   endfunction

   // Scoreboard compare at the falling edge, mid-cycle
   always @(negedge clk) begin
      if (sb.size() != 0) begin
         exp_t        e;
         logic [13:0] obs;
         e   = sb.pop_front();
         obs = observed();
         checks++;
         assert (obs === e.val) else begin
            errors++;
            $error("FAIL %s: observed stall/flush/pc/busy/state=%b expected %b", e.tag, obs, e.val);
         end
      end
   end

   task automatic drive(input logic ld, input logic mcs, input logic [CNT_W-1:0] mcc,
                        input logic mreq, input logic mrdy, input logic br);
      sched.ld_use_hazard = ld;
      sched.mc_start      = mcs;
      sched.mc_cycles     = mcc;
      sched.mem_req       = mreq;
      sched.mem_ready     = mrdy;
      sched.branch_taken  = br;
   endtask

   // One cycle: drive after the rising edge, queue the expected outputs
   task automatic step(input string tag,
                       input logic ld, input logic mcs, input logic [CNT_W-1:0] mcc,
                       input logic mreq, input logic mrdy, input logic br,
                       input logic [4:0] st, input logic [4:0] fl,
                       input logic pc, input logic busy, input logic [1:0] s);
      @(posedge clk);
      #1;
      drive(ld, mcs, mcc, mreq, mrdy, br);
      sb.push_back('{tag: tag, val: {st, fl, pc, busy, s}});
   endtask

   task automatic check_now(input string tag, input logic [13:0] exp_val);
      logic [13:0] obs;
      obs = observed();
      checks++;
      assert (obs === exp_val) else begin
         errors++;
         $error("FAIL %s: observed stall/flush/pc/busy/state=%b expected %b", tag, obs, exp_val);
      end
   endtask

   initial begin
      // Test 1: reset, then idle
      reset = 1'b0;
      drive(1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      check_now("in_reset", 14'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step("idle", 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 5'b00000, 5'b00000, 1'b0, 1'b0, 2'd0);
      end

      // Test 2: load-use, one cycle
      step("ld_use", 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 5'b00011, 5'b00100, 1'b0, 1'b0, 2'd0);
      step("ld_use_after", 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 5'b00000, 5'b00000, 1'b0, 1'b0, 2'd0);

      // Test 3: multi-cycle ops of 4, 2, 1 and 0 cycles
      step("mc4_issue", 1'b0, 1'b1, 6'd4, 1'b0, 1'b0, 1'b0, 5'b00111, 5'b01000, 1'b0, 1'b0, 2'd0);
      step("mc4_c2", 1'b0, 1'b1, 6'd4, 1'b0, 1'b0, 1'b0, 5'b00111, 5'b01000, 1'b0, 1'b1, 2'd1);
      step("mc4_c3", 1'b0, 1'b1, 6'd4, 1'b0, 1'b0, 1'b0, 5'b00111, 5'b01000, 1'b0, 1'b1, 2'd1);
      step("mc4_done", 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 5'b00000, 5'b00000, 1'b0, 1'b0, 2'd0);
      step("mc2_issue", 1'b0, 1'b1, 6'd2, 1'b0, 1'b0, 1'b0, 5'b00111, 5'b01000, 1'b0, 1'b0, 2'd0);
      step("mc2_done", 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 5'b00000, 5'b00000, 1'b0, 1'b0, 2'd0);
      step("mc1_nostall", 1'b0, 1'b1, 6'd1, 1'b0, 1'b0, 1'b0, 5'b00000, 5'b00000, 1'b0, 1'b0, 2'd0);
      step("mc0_nostall", 1'b0, 1'b1, 6'd0, 1'b0, 1'b0, 1'b0, 5'b00000, 5'b00000, 1'b0, 1'b0, 2'd0);
      step("mc_idle", 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 5'b00000, 5'b00000, 1'b0, 1'b0, 2'd0);

      // Test 4: memory wait has priority over a pending 3-cycle op
      step("mem_w1", 1'b0, 1'b1, 6'd3, 1'b1, 1'b0, 1'b0, 5'b01111, 5'b10000, 1'b0, 1'b0, 2'd0);
      step("mem_w2", 1'b0, 1'b1, 6'd3, 1'b1, 1'b0, 1'b0, 5'b01111, 5'b10000, 1'b0, 1'b0, 2'd2);
      step("mem_w3", 1'b0, 1'b1, 6'd3, 1'b1, 1'b0, 1'b0, 5'b01111, 5'b10000, 1'b0, 1'b0, 2'd2);
      step("mem_rdy", 1'b0, 1'b1, 6'd3, 1'b1, 1'b1, 1'b0, 5'b00000, 5'b00000, 1'b0, 1'b0, 2'd2);
      step("mem_mc3_issue", 1'b0, 1'b1, 6'd3, 1'b0, 1'b0, 1'b0, 5'b00111, 5'b01000, 1'b0, 1'b0, 2'd0);
      step("mem_mc3_c2", 1'b0, 1'b1, 6'd3, 1'b0, 1'b0, 1'b0, 5'b00111, 5'b01000, 1'b0, 1'b1, 2'd1);
      step("mem_mc3_done", 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 5'b00000, 5'b00000, 1'b0, 1'b0, 2'd0);

      // Test 5: branch priority
      step("br_ld", 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1, 5'b00000, 5'b00011, 1'b1, 1'b0, 2'd0);
      step("br_mc", 1'b0, 1'b1, 6'd5, 1'b0, 1'b0, 1'b1, 5'b00000, 5'b00011, 1'b1, 1'b0, 2'd0);
      step("br_after", 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 5'b00000, 5'b00000, 1'b0, 1'b0, 2'd0);
      step("mem_over_br", 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b1, 5'b01111, 5'b10000, 1'b0, 1'b0, 2'd0);
      step("mem_over_br_rdy", 1'b0, 1'b0, 6'd0, 1'b1, 1'b1, 1'b0, 5'b00000, 5'b00000, 1'b0, 1'b0, 2'd2);
      step("mem_over_br_idle", 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 5'b00000, 5'b00000, 1'b0, 1'b0, 2'd0);

      // Test 6: asynchronous reset in the middle of a 10-cycle op
      step("mc10_issue", 1'b0, 1'b1, 6'd10, 1'b0, 1'b0, 1'b0, 5'b00111, 5'b01000, 1'b0, 1'b0, 2'd0);
      step("mc10_c2", 1'b0, 1'b1, 6'd10, 1'b0, 1'b0, 1'b0, 5'b00111, 5'b01000, 1'b0, 1'b1, 2'd1);
      @(posedge clk);
      #1;
      check_now("mc10_c3_pre_rst", {5'b00111, 5'b01000, 1'b0, 1'b1, 2'd1});
      #2;
      reset = 1'b0;
      #1;
      check_now("rst_async", 14'd0);
      @(posedge clk);
      #1;
`ifdef PIPE_PERF_CNT_EN
      checks++;
      assert (sched.perf_stall_cyc === 32'd0) else begin
         errors++;
         $error("FAIL perf_stall_rst: observed %0d expected 0", sched.perf_stall_cyc);
      end
      checks++;
      assert (sched.perf_flush_evt === 32'd0) else begin
         errors++;
         $error("FAIL perf_flush_rst: observed %0d expected 0", sched.perf_flush_evt);
      end
`endif
      reset = 1'b1;
      drive(1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
      step("post_rst_idle", 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 5'b00000, 5'b00000, 1'b0, 1'b0, 2'd0);
      step("post_rst_ld", 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 5'b00011, 5'b00100, 1'b0, 1'b0, 2'd0);
      step("post_rst_mc2", 1'b0, 1'b1, 6'd2, 1'b0, 1'b0, 1'b0, 5'b00111, 5'b01000, 1'b0, 1'b0, 2'd0);
      step("post_rst_br", 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1, 5'b00000, 5'b00011, 1'b1, 1'b0, 2'd0);
      step("post_rst_done", 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 5'b00000, 5'b00000, 1'b0, 1'b0, 2'd0);
      @(negedge clk);
      #1;
`ifdef PIPE_PERF_CNT_EN
      // ld, mc2 and br cycles after reset: two stall cycles, one redirect
      checks++;
      assert (sched.perf_stall_cyc === 32'd2) else begin
         errors++;
         $error("FAIL perf_stall_cnt: observed %0d expected 2", sched.perf_stall_cyc);
      end
      checks++;
      assert (sched.perf_flush_evt === 32'd1) else begin
         errors++;
         $error("FAIL perf_flush_cnt: observed %0d expected 1", sched.perf_flush_evt);
      end
`endif
      checks++;
      assert (sb.size() == 0) else begin
         errors++;
         $error("FAIL sb_drain: observed %0d pending expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/pipe_hazard_sched.md
Name: pipe_hazard_sched

Overview:
- Central stall/flush scheduler for the 5-stage RISC-V pipeline (IF, ID, EX, MEM, WB).
- Arbitrates between four event sources: data-memory wait, taken branch, multi-cycle EX op, and load-use hazard.
- Produces per-stage hold and bubble-injection vectors plus a PC redirect strobe.
- Contains a small FSM and a down-counter that sequence multi-cycle and memory-wait stalls.

Parameters:
CNT_W, 6, width of mc_cycles and the internal multi-cycle counter.

Ports:
clk  input  1  pipeline clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
ld_use_hazard  input  1  ID reads rd of a load currently in EX
mc_start  input  1  EX holds a multi-cycle op (mul/div) in its issue cycle
mc_cycles  input  CNT_W  total EX occupancy of that op, in cycles
mem_req  input  1  MEM stage instruction accesses data memory
mem_ready  input  1  data memory completes the access this cycle
branch_taken  input  1  EX resolved a taken branch or jump
stall_stage  output  5  hold vector; bit0=IF, bit1=ID, bit2=EX, bit3=MEM, bit4=WB
flush_stage  output  5  bubble-insert vector into the named stage, same bit order
pc_redirect  output  1  select branch target as next PC
mc_busy  output  1  FSM is in MC_STALL
state_o  output  2  current FSM state, for debug

Behaviour:
- FSM states: RUN=0, MC_STALL=1, MEM_STALL=2. Internal counter cnt is CNT_W bits wide.
- While reset=0 (asynchronous): state=RUN, cnt=0, and all outputs are forced to 0.
- Outputs are combinational from state and current-cycle inputs. The stall is effective in the same cycle as detection.
- Upstream logic keeps hazard inputs asserted while their stage is held. No input latching is required.
- In RUN, the first matching condition wins:
  1. Memory wait, mem_req && !mem_ready: stall=01111, flush=10000. Next state is MEM_STALL.
  2. Branch, branch_taken: flush=00011, pc_redirect=1, stall=00000. The FSM stays in RUN, and ld_use_hazard/mc_start are ignored this cycle.
  3. Multi-cycle op, mc_start && mc_cycles>=2: stall=00111, flush=01000. cnt<=mc_cycles-2. If mc_cycles==2 the FSM stays in RUN; otherwise next state is MC_STALL.
  4. Load-use, ld_use_hazard: stall=00011, flush=00100, for one cycle. The FSM stays in RUN.
  5. Otherwise all outputs are 0.
- mc_start with mc_cycles of 0 or 1 is treated as a single-cycle op: no stall.
- MC_STALL:
  - Outputs stall=00111, flush=01000, mc_busy=1.
  - Each cycle cnt<=cnt-1. When cnt==1, this is the last stall cycle and next state is RUN.
  - Total stall cycles for an op equal mc_cycles-1, including the issue cycle.
  - Inputs other than reset are ignored in this state.
- MEM_STALL:
  - While mem_ready=0: stall=01111, flush=10000.
  - When mem_ready=1: outputs are 0 that cycle and next state is RUN.
- cnt never underflows. Its value is don't-care outside MC_STALL and is held at 0 in RUN.
- Reset asserted mid-stall aborts immediately to RUN with outputs 0.

Optional Feature:
Macro: PIPE_PERF_CNT_EN
- Defined:
  - Adds output perf_stall_cyc[31:0], which increments every cycle stall_stage!=0.
  - Adds output perf_flush_evt[31:0], which increments every cycle pc_redirect=1.
  - Both counters are cleared by reset and wrap modulo 2^32.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
1. Reset then idle (all inputs 0), release reset. Required: state_o=0, stall=00000, flush=00000, pc_redirect=0 for 10 cycles.
2. ld_use_hazard=1 for 1 cycle. Required: that cycle stall=00011, flush=00100; next cycle all outputs 0, state_o=0.
3. mc_start=1, mc_cycles=4. Required: stall=00111 for exactly 3 consecutive cycles and mc_busy=1 on cycles 2–3. Repeat with mc_cycles=2: exactly 1 stall cycle, mc_busy stays 0. Repeat with mc_cycles=1: no stall.
4. mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1, with mc_start=1 and mc_cycles=3 held throughout. Required: stall=01111 for 3 cycles, then a 0-output cycle, then the multi-cycle sequence (stall=00111 for 2 cycles).
5. branch_taken=1 and ld_use_hazard=1 together. Required: flush=00011, pc_redirect=1, stall=00000.
6. Start mc_cycles=10, assert reset=0 on cycle 3. Required: outputs 0 immediately (asynchronously), state_o=0, and normal operation after release. With PIPE_PERF_CNT_EN defined, perf_stall_cyc=0 after reset.
